cache_write_buffer: RTL

//   Posted write buffer between the cache's memory-write port (CMWr/MDataOut/WrAddrIn side) and the RAM.

---
 rtl/cache_write_buffer_if.sv | 35 +++
 rtl/cache_write_buffer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/cache_write_buffer_if.sv
// Bus bundle for the cache write buffer: cache write port, miss lookup,
// RAM write port and flush control. Clock and reset stay outside.
interface cache_write_buffer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int PTR_W  = 2
);
    logic              WrReq;
    logic [ADDR_W-1:0] WrAddr;
    logic [DATA_W-1:0] WrData;
    logic              WrRdy;
    logic              RdReq;
    logic [ADDR_W-1:0] RdAddr;
    logic              FwdHit;
    logic [DATA_W-1:0] FwdData;
    logic              MWr;
    logic [ADDR_W-1:0] MAddr;
    logic [DATA_W-1:0] MData;
    logic              MAck;
    logic              Flush;
    logic              FlushDone;
    logic [PTR_W:0]    Count;

    // Cache / RAM side that drives requests and acknowledges.
    modport master (
        output WrReq, WrAddr, WrData, RdReq, RdAddr, MAck, Flush,
        input  WrRdy, FwdHit, FwdData, MWr, MAddr, MData, FlushDone, Count
    );

    // The buffer itself.
    modport slave (
        input  WrReq, WrAddr, WrData, RdReq, RdAddr, MAck, Flush,
        output WrRdy, FwdHit, FwdData, MWr, MAddr, MData, FlushDone, Count
    );
endinterface

// File: rtl/cache_write_buffer.sv
// Posted write buffer between the cache write port and RAM.
// In-order drain, coalescing of repeat writes to a queued address
// (never into the entry currently being written to RAM), and
// youngest-match read forwarding so a miss never sees stale RAM.
module cache_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                 CLK,
    input  logic                 CLR,
    cache_write_buffer_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [PTR_W:0] COUNT_ZERO = {(PTR_W+1){1'b0}};
    localparam logic [PTR_W:0] COUNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] COUNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [ADDR_W-1:0] addr_r [DEPTH];
    logic [DATA_W-1:0] data_r [DEPTH];
    logic [PTR_W-1:0]  head_r;
    logic [PTR_W-1:0]  tail_r;
    logic [PTR_W:0]    count_r;
    state_t            state_r;
    logic              flush_done_r;

    state_t            state_next_s;
    logic              flush_done_next_s;
    logic [PTR_W:0]    count_next_s;
    logic              full_s;
    logic              wr_rdy_s;
    logic              mwr_s;
    logic              accept_s;
    logic              pop_s;
    logic              push_s;
    logic              coal_hit_s;
    logic [PTR_W-1:0]  coal_idx_s;
    logic              fwd_hit_s;
    logic [DATA_W-1:0] fwd_data_s;

    assign full_s   = (count_r == COUNT_FULL);
    assign wr_rdy_s = !full_s && (state_r != ST_FLUSH);
    // The head is in flight whenever a draining state has something queued.
    assign mwr_s    = (state_r != ST_IDLE) && (count_r != COUNT_ZERO);
    assign accept_s = bus.WrReq && wr_rdy_s;
    assign pop_s    = mwr_s && bus.MAck;
    assign push_s   = accept_s && !coal_hit_s;

    // Associative search over live entries, oldest to youngest, so the last
    // match wins: coalesce target for writes and forwarding source for reads.
    always_comb begin
        logic [PTR_W-1:0] idx_v;
        logic             live_v;
        logic             wr_m_v;
        logic             rd_m_v;
        idx_v      = {PTR_W{1'b0}};
        live_v     = 1'b0;
        wr_m_v     = 1'b0;
        rd_m_v     = 1'b0;
        coal_hit_s = 1'b0;
        coal_idx_s = {PTR_W{1'b0}};
        fwd_hit_s  = 1'b0;
        fwd_data_s = {DATA_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            idx_v      = head_r + PTR_W'(i);
            live_v     = ((PTR_W+1)'(i) < count_r);
            wr_m_v     = live_v && (addr_r[idx_v] == bus.WrAddr) && !((i == 0) && mwr_s);
            rd_m_v     = live_v && (addr_r[idx_v] == bus.RdAddr) && bus.RdReq;
            coal_hit_s = coal_hit_s | wr_m_v;
            coal_idx_s = wr_m_v ? idx_v : coal_idx_s;
            fwd_hit_s  = fwd_hit_s | rd_m_v;
            fwd_data_s = rd_m_v ? data_r[idx_v] : fwd_data_s;
        end
    end

    // Occupancy after this cycle's push and pop.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + COUNT_ONE;
            2'b01:   count_next_s = count_r - COUNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // Next state and flush-complete pulse.
    always_comb begin
        state_next_s      = state_r;
        flush_done_next_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.Flush) begin
                    if (count_next_s == COUNT_ZERO) begin
                        state_next_s      = ST_IDLE;
                        flush_done_next_s = 1'b1;
                    end else begin
                        state_next_s = ST_FLUSH;
                    end
                end else if (count_r != COUNT_ZERO) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (bus.Flush) begin
                    if (count_next_s == COUNT_ZERO) begin
                        state_next_s      = ST_IDLE;
                        flush_done_next_s = 1'b1;
                    end else begin
                        state_next_s = ST_FLUSH;
                    end
                end else if (count_next_s == COUNT_ZERO) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_FLUSH: begin
                if (count_next_s == COUNT_ZERO) begin
                    state_next_s      = ST_IDLE;
                    flush_done_next_s = 1'b1;
                end else begin
                    state_next_s = ST_FLUSH;
                end
            end
            default: begin
                state_next_s      = ST_IDLE;
                flush_done_next_s = 1'b0;
            end
        endcase
    end

    // State register and flush-done pulse register.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_r      <= ST_IDLE;
            flush_done_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            flush_done_r <= flush_done_next_s;
        end
    end

    // Entry storage, pointers and occupancy; reset abandons any in-flight write.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_r[i] <= {ADDR_W{1'b0}};
                data_r[i] <= {DATA_W{1'b0}};
            end
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= COUNT_ZERO;
        end else begin
            if (push_s) begin
                addr_r[tail_r] <= bus.WrAddr;
                data_r[tail_r] <= bus.WrData;
                tail_r         <= tail_r + PTR_ONE;
            end else if (accept_s) begin
                data_r[coal_idx_s] <= bus.WrData;
            end
            if (pop_s) begin
                head_r <= head_r + PTR_ONE;
            end
            count_r <= count_next_s;
        end
    end

    assign bus.WrRdy     = wr_rdy_s;
    assign bus.MWr       = mwr_s;
    assign bus.MAddr     = mwr_s ? addr_r[head_r] : {ADDR_W{1'b0}};
    assign bus.MData     = mwr_s ? data_r[head_r] : {DATA_W{1'b0}};
    assign bus.FwdHit    = fwd_hit_s;
    assign bus.FwdData   = fwd_data_s;
    assign bus.FlushDone = flush_done_r;
    assign bus.Count     = count_r;

endmodule
